arbitro_enrutamiento_param: RTL and testbench

//  Parametrised VC arbiter + router between NUM_VC virtual-channel FIFOs and NUM_DEST destination FIFOs.

---
 rtl/arbitro_enrutamiento_param.sv | 161 ++++++++++++++++
 tb/tb_arbitro_enrutamiento_param.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_enrutamiento_param.sv
// ---------------------------------------------------------------------------
// arbitro_enrutamiento_param
//
// Purpose:
//   Arbiter and router between NUM_VC virtual-channel FIFOs and NUM_DEST
//   destination FIFOs. Each cycle it picks one non-empty VC and pops it. The
//   arbitration is strict priority (MODE 0, VC0 highest) or round-robin
//   (MODE 1). On the next cycle it routes the returned word to the
//   destination named by the word's DEST field.
//   Any destination pause stops new pops. Words already popped are still
//   delivered.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_L   in   asynchronous reset, active low
//   vc_data   in   VC FIFO read data, VCi = [i*DATA_W +: DATA_W],
//                  valid one cycle after its pop
//   vc_empty  in   VC FIFO empty flags (registered in the FIFOs)
//   d_pause   in   destination almost-full flags, 1 = no new pops
//   vc_pop    out  one-hot-or-zero pop strobes (combinational)
//   d_data    out  registered routed word per destination
//   d_push    out  registered push strobe per destination, at most one high
//   grant_id  out  index of the VC popped last cycle, zero-extended
//   idle      out  all VCs empty, nothing in flight, FSM in ACTIVE
// ---------------------------------------------------------------------------
module arbitro_enrutamiento_param #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 4,
  parameter int NUM_DEST = 2,
  parameter int DEST_LSB = 4,
  parameter int MODE     = 0
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [NUM_VC*DATA_W-1:0]   vc_data,
  input  logic [NUM_VC-1:0]          vc_empty,
  input  logic [NUM_DEST-1:0]        d_pause,
  output logic [NUM_VC-1:0]          vc_pop,
  output logic [NUM_DEST*DATA_W-1:0] d_data,
  output logic [NUM_DEST-1:0]        d_push,
  output logic [2:0]                 grant_id,
  output logic                       idle
);

  localparam int VC_W   = $clog2(NUM_VC);
  localparam int DEST_W = $clog2(NUM_DEST);

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [NUM_VC-1:0]   pop_dly;
  logic [VC_W-1:0]     rr_ptr;
  logic [NUM_VC-1:0]   cand;
  logic [NUM_VC-1:0]   cand_hi;
  logic [VC_W-1:0]     grant_idx;
  logic                grant_any;
  logic [DATA_W-1:0]   word;
  logic [DEST_W-1:0]   dest;
  logic [NUM_DEST-1:0] push_nxt;

  // INIT lasts exactly one cycle after reset release. Leaving PAUSED needs
  // every pause flag low.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (|d_pause) state_nxt = ST_PAUSED;
      ST_PAUSED: if (d_pause == '0) state_nxt = ST_ACTIVE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // Grant selection. cand_hi holds the candidates at or above rr_ptr. It is
  // only used in round-robin mode, so strict priority falls through to the
  // lowest-index candidate. The descending loops leave the lowest set index
  // in grant_idx.
  always_comb begin
    cand      = ~vc_empty;
    cand_hi   = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_VC; k++) begin
      cand_hi[k] = cand[k] && (MODE == 1) && (VC_W'(k) >= rr_ptr);
    end
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      if (cand[k]) begin
        grant_any = 1'b1;
        grant_idx = VC_W'(k);
      end
    end
    if (|cand_hi) begin
      for (int k = NUM_VC - 1; k >= 0; k--) begin
        if (cand_hi[k]) grant_idx = VC_W'(k);
      end
    end
  end

  // Pause is looked at directly as well as through the FSM. A pause that
  // rises mid-cycle therefore blocks the pop in that same cycle. This is
  // necessary because DEST is unknown until the word comes back.
  always_comb begin
    vc_pop = '0;
    if ((state == ST_ACTIVE) && (d_pause == '0) && grant_any) begin
      vc_pop[grant_idx] = 1'b1;
    end
  end

  // Control registers. rr_ptr only moves on an actual grant, so a cycle with
  // every VC empty leaves the rotation where it was.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state    <= ST_INIT;
      pop_dly  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      idle     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pop_dly <= vc_pop;
      if (|vc_pop) begin
        grant_id <= 3'(grant_idx);
        if (MODE == 1) begin
          rr_ptr <= (grant_idx == VC_W'(NUM_VC - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      idle <= (&vc_empty) && (pop_dly == '0) && (state == ST_ACTIVE);
    end
  end

  // The word returned for last cycle's pop is selected by the delayed one-hot
  // pop, so no encoded index is needed on the data path.
  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (pop_dly[k]) word = vc_data[k*DATA_W +: DATA_W];
    end
    dest     = word[DEST_LSB +: DEST_W];
    push_nxt = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      push_nxt[d] = (|pop_dly) && (dest == DEST_W'(d));
    end
  end

  // Output registers. Slices that are not written keep their last word. Only
  // the push strobe returns to zero on a cycle with nothing in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d_data <= '0;
      d_push <= '0;
    end else begin
      d_push <= push_nxt;
      if (|pop_dly) begin
        d_data[dest*DATA_W +: DATA_W] <= word;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// ---------------------------------------------------------------------------
// tb_arbitro_enrutamiento_param
//
// Purpose:
//   Testbench with two instances of the arbiter: dut0 uses strict priority
//   and dut1 uses round-robin. Each instance has behavioural VC FIFOs with
//   registered empty flags and one-cycle read data. A scoreboard follows
//   every popped word to its destination.
// ---------------------------------------------------------------------------
module tb_arbitro_enrutamiento_param;

  localparam int DATA_W   = 6;
  localparam int NUM_VC   = 4;
  localparam int NUM_DEST = 2;

  logic clk = 1'b0;
  logic reset_L = 1'b1;

  logic [NUM_VC-1:0]          vc_empty [2] = '{4'hF, 4'hF};
  logic [NUM_VC*DATA_W-1:0]   vc_data  [2] = '{24'h0, 24'h0};
  logic [NUM_DEST-1:0]        d_pause  [2] = '{2'b00, 2'b00};
  logic [NUM_VC-1:0]          vc_pop   [2];
  logic [NUM_DEST*DATA_W-1:0] d_data   [2];
  logic [NUM_DEST-1:0]        d_push   [2];
  logic [2:0]                 grant_id [2];
  logic                       idle     [2];

  logic [DATA_W-1:0] vcQ  [2][NUM_VC][$];
  logic [DATA_W-1:0] expQ [2][NUM_DEST][$];

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  arbitro_enrutamiento_param #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .DEST_LSB(4), .MODE(0)
  ) dut0 (
    .clk(clk), .reset_L(reset_L), .vc_data(vc_data[0]), .vc_empty(vc_empty[0]),
    .d_pause(d_pause[0]), .vc_pop(vc_pop[0]), .d_data(d_data[0]),
    .d_push(d_push[0]), .grant_id(grant_id[0]), .idle(idle[0])
  );

  arbitro_enrutamiento_param #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .DEST_LSB(4), .MODE(1)
  ) dut1 (
    .clk(clk), .reset_L(reset_L), .vc_data(vc_data[1]), .vc_empty(vc_empty[1]),
    .d_pause(d_pause[1]), .vc_pop(vc_pop[1]), .d_data(d_data[1]),
    .d_push(d_push[1]), .grant_id(grant_id[1]), .idle(idle[1])
  );

  // Counts one comparison and reports it when it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Writes one word into a VC FIFO. Its empty flag drops at the next edge.
  task automatic applyStimulus(input int m, input int vc, input logic [DATA_W-1:0] w);
    vcQ[m][vc].push_back(w);
  endtask

  // One step: move to just after the falling edge, where outputs are stable.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int pending();
    int n = 0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NUM_VC; i++) n += vcQ[m][i].size();
      for (int d = 0; d < NUM_DEST; d++) n += expQ[m][d].size();
    end
    return n;
  endfunction

  // VC FIFO model. A pop returns data at this edge, and the empty flag
  // follows the remaining occupancy. Every popped word is expected later on
  // its DEST, unless reset is active, in which case the in-flight words are
  // dropped.
  always @(posedge clk) begin
    logic [DATA_W-1:0] w;
    for (int m = 0; m < 2; m++) begin
      if (!reset_L) begin
        for (int d = 0; d < NUM_DEST; d++) expQ[m][d].delete();
      end
      if (vc_pop[m] != '0) checkOutput("pop_onehot", $countones(vc_pop[m]), 1);
      for (int i = 0; i < NUM_VC; i++) begin
        if (vc_pop[m][i]) begin
          checkOutput("pop_nonempty", vcQ[m][i].size() != 0, 1);
          if (vcQ[m][i].size() != 0) begin
            w = vcQ[m][i].pop_front();
            vc_data[m][i*DATA_W +: DATA_W] <= w;
            if (reset_L) expQ[m][w[4]].push_back(w);
          end
        end
      end
      for (int i = 0; i < NUM_VC; i++) vc_empty[m][i] <= (vcQ[m][i].size() == 0);
    end
  end

  // Scoreboard. Each push must carry the oldest outstanding word for its
  // destination.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (reset_L) begin
        if (d_push[m] != '0) checkOutput("push_onehot", $countones(d_push[m]), 1);
        for (int d = 0; d < NUM_DEST; d++) begin
          if (d_push[m][d]) begin
            checkOutput("sb_push_expected", expQ[m][d].size() != 0, 1);
            if (expQ[m][d].size() != 0)
              checkOutput("sb_data", d_data[m][d*DATA_W +: DATA_W], expQ[m][d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected values for the strict-priority back-to-back scenario, one entry
  // per cycle starting at the first pop.
  logic [3:0]  t2Pop  [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic [1:0]  t2Push [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
  logic [11:0] t2Data [8] = '{12'h000, 12'h000, 12'h440, 12'h7C0, 12'hC00, 12'hC05, 12'hC2C, 12'hC2C};

  initial begin
    int found;
    logic [3:0] popVal;

    // Reset values, and one INIT cycle without a pop.
    #1 reset_L = 1'b0;
    #1;
    checkOutput("rst_d_data", d_data[0], 0);
    checkOutput("rst_d_push", d_push[0], 0);
    checkOutput("rst_grant_id", grant_id[0], 0);
    checkOutput("rst_idle", idle[0], 0);
    checkOutput("rst_vc_pop", vc_pop[0], 0);
    applyStimulus(0, 1, 6'h1A);
    applyStimulus(0, 1, 6'h13);
    tick();
    reset_L = 1'b1;
    #1;
    checkOutput("init_no_pop", vc_pop[0], 0);
    tick();
    checkOutput("first_pop", vc_pop[0], 4'b0010);
    tick();
    checkOutput("second_pop", vc_pop[0], 4'b0010);
    checkOutput("grant_id_vc1", grant_id[0], 1);
    tick();
    checkOutput("first_push", d_push[0], 2'b10);
    checkOutput("first_data", d_data[0], 12'h680);
    checkOutput("vc1_drained", vc_pop[0], 0);

    // Reset with 0x13 still in flight. Outputs must clear right away.
    reset_L = 1'b0;
    #1;
    checkOutput("midrst_d_data", d_data[0], 0);
    checkOutput("midrst_d_push", d_push[0], 0);
    checkOutput("midrst_grant_id", grant_id[0], 0);
    checkOutput("midrst_idle", idle[0], 0);
    checkOutput("midrst_vc_pop", vc_pop[0], 0);
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    checkOutput("post_rst_idle_init", idle[0], 0);
    checkOutput("post_rst_no_replay", vc_pop[0], 0);
    checkOutput("post_rst_no_push", d_push[0], 0);
    tick();
    checkOutput("post_rst_idle", idle[0], 1);

    // Strict priority: VC0 three words with DEST=1, then VC2 two words with DEST=0.
    applyStimulus(0, 0, 6'h11);
    applyStimulus(0, 0, 6'h1F);
    applyStimulus(0, 0, 6'h30);
    applyStimulus(0, 2, 6'h05);
    applyStimulus(0, 2, 6'h2C);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("prio_pop_%0d", k), vc_pop[0], t2Pop[k]);
      checkOutput($sformatf("prio_push_%0d", k), d_push[0], t2Push[k]);
      checkOutput($sformatf("prio_data_%0d", k), d_data[0], t2Data[k]);
      if (k == 1) checkOutput("prio_gid_vc0", grant_id[0], 0);
      if (k == 4) checkOutput("prio_gid_vc2", grant_id[0], 2);
    end

    // Round-robin with every VC holding two words.
    for (int i = 0; i < NUM_VC; i++) begin
      for (int j = 0; j < 2; j++) applyStimulus(1, i, 6'(i*16 + j*5 + 1));
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      checkOutput($sformatf("rr_pop_%0d", k), vc_pop[1], (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
    end
    checkOutput("rr_ptr_wrap", dut1.rr_ptr, 0);
    checkOutput("rr_gid_last", grant_id[1], 3);

    // Round-robin: only VC3 non-empty with rr_ptr=1, then VC1, then VC0 and VC2 from rr_ptr=2.
    applyStimulus(1, 0, 6'h01);
    tick();
    checkOutput("rr4_pop_vc0", vc_pop[1], 4'b0001);
    tick();
    checkOutput("rr4_ptr_1", dut1.rr_ptr, 1);
    applyStimulus(1, 3, 6'h3F);
    tick();
    checkOutput("rr4_pop_vc3", vc_pop[1], 4'b1000);
    tick();
    checkOutput("rr4_ptr_0", dut1.rr_ptr, 0);
    checkOutput("rr4_no_pop", vc_pop[1], 0);
    applyStimulus(1, 1, 6'h22);
    tick();
    checkOutput("rr4_pop_vc1", vc_pop[1], 4'b0010);
    tick();
    checkOutput("rr4_ptr_2", dut1.rr_ptr, 2);
    applyStimulus(1, 0, 6'h0C);
    applyStimulus(1, 2, 6'h17);
    tick();
    checkOutput("rr4_pop_vc2_first", vc_pop[1], 4'b0100);
    tick();
    checkOutput("rr4_pop_vc0_after", vc_pop[1], 4'b0001);
    tick();
    checkOutput("rr4_ptr_1_again", dut1.rr_ptr, 1);

    // Pause rises after a pop. The popped word 0x25 is still delivered.
    tick();
    applyStimulus(0, 0, 6'h25);
    applyStimulus(0, 0, 6'h0A);
    tick();
    checkOutput("pause_pre_pop", vc_pop[0], 4'b0001);
    tick();
    d_pause[0] = 2'b01;
    #1;
    checkOutput("pause_blocks_pop", vc_pop[0], 0);
    tick();
    checkOutput("pause_inflight_push", d_push[0], 2'b01);
    checkOutput("pause_inflight_data", d_data[0], 12'hC25);
    checkOutput("pause_hold_pop_0", vc_pop[0], 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput($sformatf("pause_hold_pop_%0d", k), vc_pop[0], 0);
      checkOutput($sformatf("pause_hold_push_%0d", k), d_push[0], 0);
    end
    d_pause[0] = 2'b00;
    #1;
    found  = 0;
    popVal = '0;
    for (int k = 0; k < 3; k++) begin
      if (found == 0) begin
        if (vc_pop[0] != '0) begin
          found  = 1;
          popVal = vc_pop[0];
        end else begin
          tick();
        end
      end
    end
    checkOutput("resume_found", found, 1);
    checkOutput("resume_pop_vc0", popVal, 4'b0001);

    // Random streams and random pause, on both instances.
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        d_pause[m] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if ($urandom_range(0, 1) == 1) begin
          int v;
          v = $urandom_range(0, NUM_VC - 1);
          if (vcQ[m][v].size() < 6) applyStimulus(m, v, 6'($urandom));
        end
      end
    end
    d_pause[0] = 2'b00;
    d_pause[1] = 2'b00;
    for (int k = 0; k < 300 && pending() != 0; k++) tick();
    checkOutput("drain_pending", pending(), 0);
    tick();
    tick();
    checkOutput("drain_idle_prio", idle[0], 1);
    checkOutput("drain_idle_rr", idle[1], 1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
